// File: rtl/pat_pkg.sv
// Shared widths, derived sizes and streamer state encoding for the pattern
// buffer slice.
package pat_pkg;

  localparam int BUFP_WIDTH   = 3;
  localparam int FIELDP_WIDTH = 5;
  localparam int BUFFER_WIDTH = 8;
  localparam int NBUF         = 1 << BUFP_WIDTH;
  localparam int NFIELD       = 1 << FIELDP_WIDTH;

  // Streamer state encoding; the enum is built on plain constants so older
  // code that compares raw bits keeps working.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM
  } stream_state_e;

endpackage

// File: rtl/pattern_send_fifo.sv
// Send queue: synchronous show-ahead FIFO of buffer indices, depth NBUF.
// Each buffer is queued at most once while busy, so it can never overflow.
module pattern_send_fifo
  import pat_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [BUFP_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [BUFP_WIDTH-1:0] o_dout,
  output logic                  o_empty
);

  localparam logic [BUFP_WIDTH:0] PTR_ONE = 1;

  logic [BUFP_WIDTH-1:0] r_mem [NBUF];
  logic [BUFP_WIDTH:0]   r_wr_ptr;
  logic [BUFP_WIDTH:0]   r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[BUFP_WIDTH-1:0]];

  // Pointer and storage update; push and pop may happen on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < NBUF; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[BUFP_WIDTH-1:0]] <= i_din;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/pattern_buffer.sv
// Field-addressed pattern storage with a queued byte streamer.
// Optional feature macro: PATBUF_CLEAR_ON_SEND_EN -- when defined, each field
// is zeroed on the edge its byte is accepted downstream.
module pattern_buffer
  import pat_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [BUFP_WIDTH-1:0]   i_bufp,
  input  logic [FIELDP_WIDTH-1:0] i_fieldp,
  input  logic [FIELDP_WIDTH-1:0] i_fieldwp,
  input  logic                    i_field_we,
  input  logic [BUFFER_WIDTH-1:0] i_field_wdata,
  output logic [BUFFER_WIDTH-1:0] o_field_rdata,
  input  logic                    i_send,
  output logic [NBUF-1:0]         o_buf_busy,
  output logic                    o_err,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BUFFER_WIDTH-1:0] o_out_data,
  output logic [BUFP_WIDTH-1:0]   o_out_buf,
  output logic                    o_out_last
);

  localparam logic [FIELDP_WIDTH-1:0] LAST_FIELD = FIELDP_WIDTH'(NFIELD - 1);
  localparam logic [FIELDP_WIDTH-1:0] FIELD_ONE  = 1;

  logic [BUFFER_WIDTH-1:0] r_mem [NBUF][NFIELD];
  logic [NBUF-1:0]         r_busy;
  stream_state_e           r_state;
  logic [FIELDP_WIDTH-1:0] r_cnt;
  logic [BUFFER_WIDTH-1:0] r_rdata;
  logic                    r_err;
  logic                    r_out_valid;
  logic [BUFFER_WIDTH-1:0] r_out_data;
  logic [BUFP_WIDTH-1:0]   r_out_buf;

  logic                    w_sel_busy;
  logic                    w_wr_ok;
  logic                    w_send_ok;
  logic                    w_accept;
  logic                    w_last_acc;
  logic                    w_fifo_empty;
  logic                    w_fifo_pop;
  logic [BUFP_WIDTH-1:0]   w_fifo_dout;
  logic [FIELDP_WIDTH-1:0] w_cnt_nxt;
  logic [NBUF-1:0]         w_busy_nxt;

  assign w_sel_busy = r_busy[i_bufp];
  assign w_wr_ok    = i_field_we & ~w_sel_busy;
  assign w_send_ok  = i_send & ~w_sel_busy;
  assign w_accept   = r_out_valid & i_out_ready;
  assign w_last_acc = w_accept & (r_cnt == LAST_FIELD);
  assign w_fifo_pop = ~w_fifo_empty & ((r_state == IDLE) | w_last_acc);
  assign w_cnt_nxt  = r_cnt + FIELD_ONE;

  assign o_field_rdata = r_rdata;
  assign o_buf_busy    = r_busy;
  assign o_err         = r_err;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_out_buf     = r_out_buf;
  assign o_out_last    = (r_cnt == LAST_FIELD);

  pattern_send_fifo u_send_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_send_ok),
    .i_din   (i_bufp),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty)
  );

  // Core writes to idle buffers; optionally wipe each field as it leaves.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < NBUF; b++)
        for (int f = 0; f < NFIELD; f++) r_mem[b][f] <= '0;
    end else begin
      if (w_wr_ok) r_mem[i_bufp][i_fieldwp] <= i_field_wdata;
`ifdef PATBUF_CLEAR_ON_SEND_EN
      if (w_accept) r_mem[r_out_buf][r_cnt] <= '0;
`else
`endif
    end
  end

  // Registered read port; a colliding write is not bypassed (old byte wins).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= r_mem[i_bufp][i_fieldp];
      r_err   <= (i_field_we | i_send) & w_sel_busy;
    end
  end

  // Busy set on an accepted send, cleared when the last byte leaves.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_last_acc) w_busy_nxt[r_out_buf] = 1'b0;
    if (w_send_ok)  w_busy_nxt[i_bufp]    = 1'b1;
  end

  // Busy register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Streamer: pops queued buffers and presents one field per accepted byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_buf   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_out_buf   <= w_fifo_dout;
            r_out_data  <= r_mem[w_fifo_dout][0];
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            if (r_cnt != LAST_FIELD) begin
              r_cnt      <= w_cnt_nxt;
              r_out_data <= r_mem[r_out_buf][w_cnt_nxt];
            end else if (!w_fifo_empty) begin
              r_out_buf  <= w_fifo_dout;
              r_out_data <= r_mem[w_fifo_dout][0];
              r_cnt      <= '0;
            end else begin
              r_out_valid <= 1'b0;
              r_cnt       <= '0;
              r_state     <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_buffer.sv
module tb_pattern_buffer;
  import pat_pkg::*;

  logic                    i_clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic [BUFP_WIDTH-1:0]   i_bufp = '0;
  logic [FIELDP_WIDTH-1:0] i_fieldp = '0;
  logic [FIELDP_WIDTH-1:0] i_fieldwp = '0;
  logic                    i_field_we = 1'b0;
  logic [BUFFER_WIDTH-1:0] i_field_wdata = '0;
  logic [BUFFER_WIDTH-1:0] o_field_rdata;
  logic                    i_send = 1'b0;
  logic [NBUF-1:0]         o_buf_busy;
  logic                    o_err;
  logic                    o_out_valid;
  logic                    i_out_ready = 1'b0;
  logic [BUFFER_WIDTH-1:0] o_out_data;
  logic [BUFP_WIDTH-1:0]   o_out_buf;
  logic                    o_out_last;

  pattern_buffer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bufp(i_bufp), .i_fieldp(i_fieldp),
    .i_fieldwp(i_fieldwp), .i_field_we(i_field_we), .i_field_wdata(i_field_wdata),
    .o_field_rdata(o_field_rdata), .i_send(i_send), .o_buf_busy(o_buf_busy),
    .o_err(o_err), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_buf(o_out_buf), .o_out_last(o_out_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [BUFP_WIDTH-1:0]   b;
    logic [FIELDP_WIDTH-1:0] f;
    logic [BUFFER_WIDTH-1:0] d;
  } ent_t;

  // Reference model: byte array, busy set, and the flat list of bytes owed.
  logic [BUFFER_WIDTH-1:0] mem_m [NBUF][NFIELD];
  logic [NBUF-1:0]         busy_m = '0;
  ent_t                    exp_q[$];
  int                      n_checks = 0;
  int                      n_pass = 0;
  int                      n_acc = 0;
  bit                      stall_prev = 0;
  logic [BUFFER_WIDTH-1:0] stall_data;
  logic [BUFP_WIDTH-1:0]   stall_buf;
  logic                    stall_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int b = 0; b < NBUF; b++)
      for (int f = 0; f < NFIELD; f++) mem_m[b][f] = '0;
    busy_m = '0;
    exp_q.delete();
    stall_prev = 0;
  endtask

  // One clock: predict from pre-edge inputs/model, advance, check post-edge.
  task automatic step();
    logic [NBUF-1:0]         busy_old;
    logic [BUFFER_WIDTH-1:0] rd_e;
    logic                    err_e;
    ent_t                    e;
    busy_old = busy_m;
    rd_e  = mem_m[i_bufp][i_fieldp];
    err_e = (i_field_we | i_send) & busy_old[i_bufp];
    if (stall_prev) begin
      check("stall_data", 32'(o_out_data), 32'(stall_data));
      check("stall_buf",  32'(o_out_buf),  32'(stall_buf));
      check("stall_last", 32'(o_out_last), 32'(stall_last));
    end
    stall_prev = o_out_valid & ~i_out_ready;
    stall_data = o_out_data;
    stall_buf  = o_out_buf;
    stall_last = o_out_last;
    if (o_out_valid && i_out_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        check("spurious_byte", 32'(o_out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(o_out_data), 32'(e.d));
        check("out_buf",  32'(o_out_buf),  32'(e.b));
        check("out_last", 32'(o_out_last), 32'(e.f == FIELDP_WIDTH'(NFIELD - 1)));
`ifdef PATBUF_CLEAR_ON_SEND_EN
        mem_m[e.b][e.f] = '0;
`endif
        if (e.f == FIELDP_WIDTH'(NFIELD - 1)) busy_m[e.b] = 1'b0;
      end
    end
    if (i_field_we && !busy_old[i_bufp]) mem_m[i_bufp][i_fieldwp] = i_field_wdata;
    if (i_send && !busy_old[i_bufp]) begin
      for (int k = 0; k < NFIELD; k++)
        exp_q.push_back('{b: i_bufp, f: FIELDP_WIDTH'(k), d: mem_m[i_bufp][k]});
      busy_m[i_bufp] = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check("err", 32'(o_err), 32'(err_e));
    check("field_rdata", 32'(o_field_rdata), 32'(rd_e));
    check("buf_busy", 32'(o_buf_busy), 32'(busy_m));
  endtask

  task automatic fill(input logic [BUFP_WIDTH-1:0] b, input bit ramp);
    for (int k = 0; k < NFIELD; k++) begin
      i_bufp        = b;
      i_fieldwp     = FIELDP_WIDTH'(k);
      i_fieldp      = FIELDP_WIDTH'($urandom);
      i_field_wdata = ramp ? BUFFER_WIDTH'(k + 16) : BUFFER_WIDTH'($urandom);
      i_field_we    = 1'b1;
      step();
    end
    i_field_we = 1'b0;
  endtask

  task automatic drain(input bit rand_ready, input bit no_bubble, input int budget);
    int n;
    bit started;
    n = 0;
    started = 0;
    i_field_we = 1'b0;
    i_send = 1'b0;
    while (exp_q.size() > 0 && n < budget) begin
      i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_bufp      = BUFP_WIDTH'($urandom);
      i_fieldp    = FIELDP_WIDTH'($urandom);
      if (no_bubble && started) check("no_bubble", 32'(o_out_valid), 32'(1));
      if (o_out_valid) started = 1;
      step();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge i_clk);
    check("rst_rdata", 32'(o_field_rdata), 32'(0));
    check("rst_busy",  32'(o_buf_busy),    32'(0));
    check("rst_err",   32'(o_err),         32'(0));
    check("rst_valid", 32'(o_out_valid),   32'(0));
    check("rst_data",  32'(o_out_data),    32'(0));
    check("rst_buf",   32'(o_out_buf),     32'(0));
    check("rst_last",  32'(o_out_last),    32'(0));
    i_rst = 1'b0;
    @(negedge i_clk);

    // Write then read back, including a colliding read.
    i_bufp = 3'd2; i_fieldwp = 5'd7; i_fieldp = 5'd7;
    i_field_wdata = 8'hA5; i_field_we = 1'b1;
    step();
    check("rd_during_wr", 32'(o_field_rdata), 32'h00);
    i_field_we = 1'b0;
    step();
    check("rd_after_wr", 32'(o_field_rdata), 32'hA5);

    // Basic stream of a ramp buffer.
    i_out_ready = 1'b1;
    fill(3'd1, 1'b1);
    i_bufp = 3'd1; i_send = 1'b1;
    step();
    check("valid_after_t", 32'(o_out_valid), 32'(0));
    i_send = 1'b0;
    step();
    check("valid_after_t1", 32'(o_out_valid), 32'(1));
    check("first_byte", 32'(o_out_data), 32'h10);
    drain(1'b0, 1'b1, 100);
    check("idle_after_stream", 32'(o_out_valid), 32'(0));

    // Back-to-back buffers with no bubble.
    fill(3'd3, 1'b0);
    fill(3'd0, 1'b0);
    i_bufp = 3'd3; i_send = 1'b1;
    step();
    i_bufp = 3'd0;
    step();
    i_send = 1'b0;
    drain(1'b0, 1'b1, 200);

    // Backpressure with random ready.
    fill(3'd5, 1'b0);
    i_bufp = 3'd5; i_send = 1'b1;
    step();
    i_send = 1'b0;
    drain(1'b1, 1'b0, 1000);

    // Rejections while buf 1 is busy and stalled.
    i_out_ready = 1'b0;
    i_bufp = 3'd1; i_send = 1'b1;
    step();
    i_send = 1'b0;
    step();
    step();
    i_field_we = 1'b1; i_fieldwp = 5'd3; i_field_wdata = 8'hEE;
    step();
    check("err_on_write", 32'(o_err), 32'(1));
    i_field_we = 1'b0; i_send = 1'b1;
    step();
    check("err_on_send", 32'(o_err), 32'(1));
    i_send = 1'b0;
    step();
    check("err_one_cycle", 32'(o_err), 32'(0));
    drain(1'b0, 1'b0, 100);
    i_bufp = 3'd1; i_fieldp = 5'd3;
    step();
    check("unchanged_after_reject", 32'(o_field_rdata), 32'h13);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      i_bufp        = BUFP_WIDTH'($urandom);
      i_fieldp      = FIELDP_WIDTH'($urandom);
      i_fieldwp     = FIELDP_WIDTH'($urandom);
      i_field_wdata = BUFFER_WIDTH'($urandom);
      i_field_we    = ($urandom_range(0, 2) == 0);
      i_send        = ($urandom_range(0, 11) == 0);
      i_out_ready   = 1'($urandom_range(0, 1));
      step();
    end
    drain(1'b1, 1'b0, 3000);

`ifdef PATBUF_CLEAR_ON_SEND_EN
    fill(3'd6, 1'b1);
    i_bufp = 3'd6; i_send = 1'b1;
    step();
    i_send = 1'b0;
    drain(1'b0, 1'b0, 100);
    for (int k = 0; k < NFIELD; k++) begin
      i_bufp = 3'd6; i_fieldp = FIELDP_WIDTH'(k);
      step();
      check("cleared_after_send", 32'(o_field_rdata), 32'(0));
    end
`endif

    // Reset mid-stream after 5 accepted bytes.
    fill(3'd1, 1'b1);
    i_out_ready = 1'b1;
    i_bufp = 3'd1; i_send = 1'b1;
    step();
    i_send = 1'b0;
    begin
      int start_acc;
      int guard;
      start_acc = n_acc;
      guard = 0;
      while (n_acc < start_acc + 5 && guard < 50) begin
        step();
        guard++;
      end
      if (n_acc < start_acc + 5) check("reset_wait_timeout", 32'(n_acc - start_acc), 32'(5));
    end
    i_rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(o_out_valid), 32'(0));
    check("rst_mid_busy",  32'(o_buf_busy),  32'(0));
    check("rst_mid_last",  32'(o_out_last),  32'(0));
    model_clear();
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < NFIELD; k++) begin
      i_bufp = 3'd1; i_fieldp = FIELDP_WIDTH'(k);
      step();
    end
    check("rst_array_zero", 32'(o_field_rdata), 32'(0));
    repeat (3) step();
    check("final_valid", 32'(o_out_valid), 32'(0));
    check("final_queue", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_buffer.md
# pattern_buffer

Field-addressed pattern storage and transmit stage directly downstream of the `pat` core. It holds 2^BUFP_WIDTH buffers of 2^FIELDP_WIDTH byte fields. The core reads and writes fields through its `bufp`/`fieldp`/`fieldwp` pointers. When the core commits a buffer, the block queues it and streams it out byte-by-byte over a valid/ready link toward the output serializer.

## Interface
- `BUFP_WIDTH`, 3, buffer-select width; NBUF = 2^BUFP_WIDTH
- `FIELDP_WIDTH`, 5, field-pointer width; NFIELD = 2^FIELDP_WIDTH
- `BUFFER_WIDTH`, 8, field byte width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `bufp`  in  BUFP_WIDTH  buffer selected by the core, for reads, writes and send
- `fieldp`  in  FIELDP_WIDTH  field read pointer
- `fieldwp`  in  FIELDP_WIDTH  field write pointer
- `field_we`  in  1  write `field_wdata` to (bufp, fieldwp)
- `field_wdata`  in  BUFFER_WIDTH  carries the core's `field_byte_out`
- `field_rdata`  out  BUFFER_WIDTH  drives the core's `field_byte_in`; registered
- `send`  in  1  one-cycle pulse that commits buffer `bufp` for transmission
- `buf_busy`  out  NBUF  bit b set while buffer b is queued or streaming
- `err`  out  1  one-cycle pulse when a write or send is rejected
- `out_valid`  out  1  stream byte valid
- `out_ready`  in  1  downstream accepts the byte
- `out_data`  out  BUFFER_WIDTH  stream byte
- `out_buf`  out  BUFP_WIDTH  index of the buffer being streamed
- `out_last`  out  1  marks field NFIELD-1

## Operation
- Storage is an NBUF×NFIELD register array.
- Read path:
  - `field_rdata` is loaded every cycle from (bufp, fieldp).
  - A read and a write to the same location in the same cycle returns the old byte.
- Write path:
  - `field_we` with `buf_busy[bufp]`=0 writes the field.
  - `field_we` with `buf_busy[bufp]`=1 is ignored and pulses `err`.
- Send path:
  - `send` with `buf_busy[bufp]`=0 sets the busy bit and pushes `bufp` into the send queue.
  - The send queue is a FIFO of depth NBUF. It cannot overflow, because each buffer is queued at most once.
  - `send` to a busy buffer is ignored and pulses `err`. This includes a buffer whose last byte is being accepted in the same cycle.
  - A write and a send to the same buffer in the same cycle: the write lands, then the buffer becomes busy.
- Streamer FSM:
  - IDLE: if the queue is non-empty, pop it, load field 0 of the popped buffer into the output registers, set `out_valid`=1, set the field counter to 0, and go to STREAM.
  - STREAM: on `out_valid && out_ready`, the counter increments (it cannot wrap within a buffer) and the next field is presented.
  - `out_last` = (counter == NFIELD-1).
  - When the last byte is accepted, the streamer clears `buf_busy[out_buf]`.
    - If the queue is non-empty, it pops and presents field 0 of the next buffer on the same edge, with no bubble, and stays in STREAM.
    - Otherwise it drops `out_valid` and returns to IDLE.
  - While `out_ready`=0, `out_data`, `out_buf` and `out_last` hold stable.
- Reset:
  - All outputs are 0: `field_rdata`, `buf_busy`, `err`, `out_valid`, `out_data`, `out_buf`, `out_last`.
  - The FSM is in IDLE, the queue is empty, and the array is zeroed.
  - `rst` mid-stream aborts the transfer immediately. No `out_last` is produced.

## Timing
- Read latency: 1 cycle.
- `send` sampled at edge t:
  - `buf_busy` is high after edge t.
  - `out_valid` is high after edge t+1, provided the streamer was idle and the queue was empty.
- Throughput: 1 byte/cycle with `out_ready` held high, i.e. NFIELD cycles per buffer, back-to-back.
- `buf_busy` clears at the edge that accepts `out_last`. The buffer is writable in the next cycle.
- `err` is high for exactly the cycle after the rejected request.

## Configuration
- `PATBUF_CLEAR_ON_SEND_EN` defined: each field is written to 0 at the edge its byte is accepted downstream. A sent buffer returns all-zero.
- Not defined: contents are preserved across a send, so the core can re-send or edit incrementally.

## Structure
- `pat_pkg` holds the widths (BUFP_WIDTH, FIELDP_WIDTH, BUFFER_WIDTH), NBUF and NFIELD.
- It also holds the streamer state enum (IDLE, STREAM).
- The send queue is a sub-module, `pattern_send_fifo`: synchronous FIFO of BUFP_WIDTH-bit entries, depth NBUF, with push/pop/empty.

## Test plan
- Write and read back:
  - Stimulus: write 0xA5 to (buf 2, field 7), then read (2, 7).
  - Required response: `field_rdata`=0xA5 one cycle later. A same-cycle read of (2, 7) during the write returns 0x00.
- Basic stream:
  - Stimulus: fill buf 1 with field k = k+0x10, pulse `send`, hold `out_ready`=1.
  - Required response: `out_valid` goes high 2 cycles after `send`. Bytes 0x10..0x2F arrive with `out_buf`=1, `out_last` on 0x2F, then `buf_busy[1]` clears.
- Back-to-back buffers:
  - Stimulus: send buf 3 then buf 0 on consecutive cycles.
  - Required response: 64 consecutive accepted bytes with no bubble. `out_buf` changes 3→0 immediately after the first `out_last`.
- Backpressure:
  - Stimulus: toggle `out_ready` randomly during a stream.
  - Required response: data stays stable while stalled, no byte is dropped or duplicated, order is preserved.
- Rejections:
  - Stimulus: write to buf 1 while busy; send buf 1 again while busy.
  - Required response: `err` pulses twice, contents are unchanged, and only one stream of buf 1 is produced.
- Reset mid-stream:
  - Stimulus: assert `rst` after 5 accepted bytes.
  - Required response: `out_valid`=0 and `buf_busy`=0 immediately, and the array reads 0. With `PATBUF_CLEAR_ON_SEND_EN`, a completed send leaves all 32 fields reading 0x00.
